// File: rtl/ram2114_access_ctrl_pkg.sv
// Shared defaults and encodings for the playfield/bullet RAM access controller.
package ram2114_access_ctrl_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_VID,
        SRC_CPU
    } src_t;

endpackage

// File: rtl/ram2114_access_ctrl_ram_clear_seq.sv
// Zero-fill address sequencer: walks 0..2**ADDR_W-1, one address per cycle while busy.
// Latency: busy rises the edge after start, first address issued on the following edge.
// No backpressure: once started it runs to the terminal count; start restarts it at 0.
module ram2114_access_ctrl_ram_clear_seq
    import ram2114_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    // One spare bit so the terminal address is seen as a carry, not a wrap to 0.
    logic [ADDR_W:0] cnt;
    logic [ADDR_W:0] cnt_nxt;

    assign cnt_nxt = cnt + 1'b1;
    assign addr    = cnt[ADDR_W-1:0];
    assign last    = busy & cnt_nxt[ADDR_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            busy <= ~last;
            cnt  <= last ? '0 : cnt_nxt;
        end
    end

endmodule

// File: rtl/ram2114_access_ctrl.sv
// Sole owner of the 2114-style RAM port: video reads beat CPU ops, plus a zero-fill clear engine.
// Latency: grant at edge k -> RAM latches address at k+1 -> data/ack registered at k+2.
// Backpressure: CPU waits (req held) behind video and clear; video requests during clear are dropped.
module ram2114_access_ctrl
    import ram2114_access_ctrl_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_dout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    state_t            state;
    src_t              tag0;
    src_t              tag1;
    logic              rd0;
    logic              rd1;
    logic              cpu_pend;
    logic              clr_start;
    logic              clr_last;
    logic [ADDR_W-1:0] clr_addr;

    // In CLEAR with the sequencer idle only happens on the first edge out of reset.
    assign clr_start = (state == ST_RUN) ? clear_req : ~clear_busy;

    ram2114_access_ctrl_ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk   (clk),
        .reset (reset),
        .start (clr_start),
        .busy  (clear_busy),
        .addr  (clr_addr),
        .last  (clr_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_data  <= '0;
            cpu_pend  <= 1'b0;
            tag0      <= SRC_NONE;
            tag1      <= SRC_NONE;
            rd0       <= 1'b0;
            rd1       <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= '0;
            cpu_ack   <= 1'b0;
            cpu_dout  <= '0;
        end else begin
            ram_we <= 1'b0;
            tag0   <= SRC_NONE;
            rd0    <= 1'b0;
            tag1   <= tag0;
            rd1    <= rd0;

            // Return stage keeps draining in CLEAR: the RAM already holds those addresses.
            vid_valid <= (tag1 == SRC_VID);
            cpu_ack   <= (tag1 == SRC_CPU);
            if (tag1 == SRC_VID) begin
                vid_data <= ram_q;
            end
            if (tag1 == SRC_CPU) begin
                cpu_pend <= 1'b0;
                if (rd1) begin
                    cpu_dout <= ram_q;
                end
            end

            case (state)
                ST_CLEAR: begin
                    if (clear_busy) begin
                        ram_we   <= 1'b1;
                        ram_addr <= clr_addr;
                        ram_data <= '0;
                    end
                    if (clr_last) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                    end else if (vid_req) begin
                        ram_addr <= vid_addr;
                        tag0     <= SRC_VID;
                    end else if (cpu_req && !cpu_pend) begin
                        ram_addr <= cpu_addr;
                        ram_we   <= cpu_we;
                        ram_data <= cpu_din;
                        tag0     <= SRC_CPU;
                        rd0      <= ~cpu_we;
                        cpu_pend <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ram2114_access_ctrl.sv
// Scoreboarded bench: behavioural RAM plus a flat-array reference of the contents and grant rules.
module tb_ram2114_access_ctrl;

    localparam int AW    = 11;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
    localparam int CLR_CYCLES = DEPTH + 1;

    typedef struct {
        int          due;
        logic [7:0]  data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_req = 1'b0;
    logic          clear_busy;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_valid;
    logic [DW-1:0] vid_data;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_run = 0;

    // Behavioural 2114-style RAM with bench-side fill/poke for preloading.
    logic [DW-1:0] ram [DEPTH];
    logic [AW-1:0] ram_addr_reg = '0;
    logic          fill_en = 1'b0;
    logic [DW-1:0] fill_val = '0;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_val = '0;

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= fill_val;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_data;
        end
        if (poke_en) ram[poke_addr] <= poke_val;
        ram_addr_reg <= ram_addr;
    end
    assign ram_q = ram[ram_addr_reg];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram2114_access_ctrl #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_valid  (vid_valid),
        .vid_data   (vid_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_ack    (cpu_ack),
        .cpu_dout   (cpu_dout),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_data   (ram_data),
        .ram_q      (ram_q)
    );

    // Reference model state
    logic [DW-1:0] mdl [DEPTH];
    exp_t          vid_q [$];
    exp_t          cpu_q [$];
    int            run_from = 0;
    logic [DW-1:0] last_dout = '0;
    logic          cpu_active = 1'b0;
    logic          cpu_granted = 1'b0;
    int            ack_edge = -1;
    logic          want_cpu = 1'b0;
    logic          want_we = 1'b0;
    logic [AW-1:0] want_addr = '0;
    logic [DW-1:0] want_din = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic zero_model();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // Drives one cycle; predicts what the next edge grants and queues the expected response.
    task automatic drive_cycle(input logic v, input logic [AW-1:0] va, input logic clr);
        int   e;
        logic dropped;
        exp_t x;
        e = cyc + 1;
        dropped = 1'b0;
        if (cpu_granted && cyc == ack_edge) begin
            cpu_req = 1'b0;
            cpu_active = 1'b0;
            cpu_granted = 1'b0;
            dropped = 1'b1;
        end
        if (want_cpu && !cpu_active && !dropped) begin
            want_cpu = 1'b0;
            cpu_active = 1'b1;
            cpu_req = 1'b1;
            cpu_we = want_we;
            cpu_addr = want_addr;
            cpu_din = want_din;
        end
        if (e >= run_from) begin
            if (clr) begin
                zero_model();
                run_from = e + CLR_CYCLES - 1;
            end else if (v) begin
                x.due = e + 2;
                x.data = mdl[va];
                vid_q.push_back(x);
            end else if (cpu_active && !cpu_granted) begin
                cpu_granted = 1'b1;
                ack_edge = e + 2;
                if (cpu_we) mdl[cpu_addr] = cpu_din;
                else last_dout = mdl[cpu_addr];
                x.due = e + 2;
                x.data = last_dout;
                cpu_q.push_back(x);
            end
        end
        vid_req = v;
        vid_addr = va;
        clear_req = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        want_cpu = 1'b1;
        want_we = we;
        want_addr = a;
        want_din = d;
        for (int n = 0; n < 64 && (want_cpu || cpu_active); n++) drive_cycle(1'b0, '0, 1'b0);
    endtask

    task automatic enter_reset();
        reset = 1'b1;
        vid_req = 1'b0;
        clear_req = 1'b0;
        cpu_req = 1'b0;
        cpu_active = 1'b0;
        cpu_granted = 1'b0;
        want_cpu = 1'b0;
        last_dout = '0;
        vid_q.delete();
        cpu_q.delete();
    endtask

    task automatic leave_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_from = cyc + 1 + CLR_CYCLES;
        zero_model();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_clear_busy"}, int'(clear_busy), 0);
        chk({tag, "_ram_we"}, int'(ram_we), 0);
        chk({tag, "_ram_addr"}, int'(ram_addr), 0);
        chk({tag, "_ram_data"}, int'(ram_data), 0);
        chk({tag, "_vid_valid"}, int'(vid_valid), 0);
        chk({tag, "_vid_data"}, int'(vid_data), 0);
        chk({tag, "_cpu_ack"}, int'(cpu_ack), 0);
        chk({tag, "_cpu_dout"}, int'(cpu_dout), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (clear_busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("clear_busy_len", busy_run, DEPTH);
                busy_run = 0;
            end
            if (vid_valid) begin
                if (vid_q.size() == 0) begin
                    chk("vid_valid_unexpected", 1, 0);
                end else begin
                    x = vid_q.pop_front();
                    chk("vid_valid_cycle", cyc, x.due);
                    chk("vid_data", int'(vid_data), int'(x.data));
                end
            end else if (vid_q.size() != 0 && vid_q[0].due <= cyc) begin
                x = vid_q.pop_front();
                chk("vid_valid_missing", 0, 1);
            end
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_ack_unexpected", 1, 0);
                end else begin
                    x = cpu_q.pop_front();
                    chk("cpu_ack_cycle", cyc, x.due);
                    chk("cpu_dout", int'(cpu_dout), int'(x.data));
                end
            end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
                x = cpu_q.pop_front();
                chk("cpu_ack_missing", 0, 1);
            end
        end
    end

    initial begin
        int rf;
        int j;
        int a0;

        // Reset state with the RAM pre-filled to 0xFF
        enter_reset();
        fill_val = 8'hFF;
        fill_en = 1'b1;
        @(posedge clk);
        #1;
        fill_en = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("reset");
        leave_reset();

        // Clear after reset: CPU read held throughout, stray video/clear requests ignored
        rf = run_from;
        want_cpu = 1'b1;
        want_we = 1'b0;
        want_addr = 11'h005;
        want_din = '0;
        while (cyc < rf + 4) begin
            logic v;
            logic c;
            v = ($urandom_range(0, 3) == 0) && (cyc + 1 < rf);
            c = ($urandom_range(0, 63) == 0) && (cyc + 2 < rf);
            if (cyc == rf - 2) chk("clear_busy_before_end", int'(clear_busy), 1);
            if (cyc == rf - 1) chk("clear_busy_after_end", int'(clear_busy), 0);
            drive_cycle(v, 11'($urandom), c);
        end

        // Every address reads back zero, one video read per cycle
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 11'(i), 1'b0);
        idle(4);

        // CPU write then read back
        cpu_op(1'b1, 11'h123, 8'hA5);
        cpu_op(1'b0, 11'h123, 8'h00);

        // Four back-to-back video reads of preloaded bytes
        for (int i = 0; i < 4; i++) cpu_op(1'b1, 11'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 11'(i), 1'b0);
        idle(4);

        // Simultaneous CPU and video requests: video wins until it goes idle
        want_cpu = 1'b1;
        want_we = 1'b1;
        want_addr = 11'h200;
        want_din = 8'h3C;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 11'(8 + i), 1'b0);
        idle(5);
        cpu_op(1'b0, 11'h200, 8'h00);

        // Clear requested one cycle after a video grant: the in-flight read still returns 0x77
        cpu_op(1'b1, 11'h050, 8'h77);
        idle(2);
        drive_cycle(1'b1, 11'h050, 1'b0);
        drive_cycle(1'b0, '0, 1'b1);
        rf = run_from;
        while (cyc < rf + 2) drive_cycle(1'b0, '0, 1'b0);
        drive_cycle(1'b1, 11'h050, 1'b0);
        drive_cycle(1'b1, 11'h123, 1'b0);
        idle(4);

        // Randomized traffic over a small address window to force read-after-write hits
        for (int i = 0; i < 1500; i++) begin
            if (!cpu_active && !want_cpu && $urandom_range(0, 3) == 0) begin
                want_cpu = 1'b1;
                want_we = 1'($urandom);
                want_addr = 11'($urandom_range(0, 31));
                want_din = 8'($urandom);
            end
            drive_cycle($urandom_range(0, 2) == 0, 11'($urandom_range(0, 31)), 1'b0);
        end
        idle(8);

        // Async reset in the middle of a clear, then the clear restarts from address 0
        drive_cycle(1'b0, '0, 1'b1);
        j = cyc;
        while (cyc < j + 12'h300) drive_cycle(1'b0, '0, 1'b0);
        #3;
        enter_reset();
        #1;
        check_outputs_zero("midclear_reset");
        poke_val = 8'hFF;
        poke_en = 1'b1;
        poke_addr = 11'h000;
        @(posedge clk);
        #1;
        poke_addr = 11'h010;
        @(posedge clk);
        #1;
        poke_addr = 11'h2FF;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
        leave_reset();
        rf = run_from;
        a0 = cyc + 1;
        while (cyc < rf + 2) begin
            if (cyc == a0 + 1) begin
                chk("restart_we", int'(ram_we), 1);
                chk("restart_addr0", int'(ram_addr), 0);
            end
            if (cyc == a0 + 2) chk("restart_addr1", int'(ram_addr), 1);
            drive_cycle(1'b0, '0, 1'b0);
        end
        drive_cycle(1'b1, 11'h000, 1'b0);
        drive_cycle(1'b1, 11'h010, 1'b0);
        drive_cycle(1'b1, 11'h2FF, 1'b0);
        drive_cycle(1'b1, 11'h7FF, 1'b0);
        idle(8);

        chk("vid_queue_drained", vid_q.size(), 0);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ram2114_access_ctrl.md
Name: ram2114_access_ctrl

Overview:
- Initiator/sequencer that owns the single port of a 2K×8 synchronous-address RAM (2114-style: address registered on clk, q = mem[addr_reg]).
- Arbitrates a fixed-priority video fetch client against a CPU req/ack client.
- Runs a zero-fill clear engine after reset or on command.
- Sits between the game logic and the playfield/bullet RAM instance.

Parameters:
- ADDR_W, 11, RAM address width (depth 2**ADDR_W).
- DATA_W, 8, RAM data width.
- CLEAR_ON_RESET, 1, 1 = enter CLEAR after reset; 0 = enter RUN.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear_req  in  1  one-cycle pulse starting a full zero-fill.
- clear_busy  out  1  high while the clear engine owns the RAM.
- vid_req  in  1  video read request, valid for one cycle per address.
- vid_addr  in  ADDR_W  video read address.
- vid_valid  out  1  one-cycle strobe marking vid_data valid.
- vid_data  out  DATA_W  returned video byte.
- cpu_req  in  1  CPU request, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_din  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_dout  out  DATA_W  read data; valid when cpu_ack=1 on a read.
- ram_addr  out  ADDR_W  to RAM addr (registered).
- ram_we  out  1  to RAM we (registered).
- ram_data  out  DATA_W  to RAM data (registered).
- ram_q  in  DATA_W  from RAM q.

Behaviour:
- Reset (async): all outputs 0; cpu pending flag cleared; return pipeline cleared; clear counter 0.
- State after reset: CLEAR if CLEAR_ON_RESET=1, else RUN.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle: ram_we=1, ram_data=0, ram_addr=counter; counter increments.
  - clear_busy=1 throughout.
  - After the edge that issues address 2**ADDR_W-1, go to RUN and drop clear_busy. Total 2**ADDR_W write cycles.
  - vid_req ignored: no vid_valid is produced for it.
  - cpu_req stalls, not acked.
  - clear_req ignored (no restart).
- RUN, per-edge grant, highest priority first:
  - (1) clear_req=1: go to CLEAR, counter reset to 0, clear_busy=1 next cycle.
  - (2) vid_req=1: issue read at vid_addr.
  - (3) cpu_req=1 with no CPU transaction in flight: issue cpu op and set pending.
  - (4) otherwise ram_we=0 and ram_addr holds its last value.
- Read latency: grant sampled at edge k; ram_addr valid after k; RAM latches at k+1; block captures ram_q at k+2.
  - Video: vid_valid=1 and vid_data for the cycle after k+2. Fully pipelined, one read per cycle.
  - CPU read: cpu_ack=1 and cpu_dout after k+2.
- CPU write: ram_we=1 and ram_data=cpu_din for one cycle after k; cpu_ack pulses after k+2, giving uniform latency. cpu_dout holds its previous value.
- CPU handshake:
  - The requester drops cpu_req in the cycle it sees cpu_ack.
  - The pending flag prevents re-grant until the ack edge.
  - cpu_req still high at edge k+3 is treated as a new transaction.
  - At most one CPU transaction is in flight.
- Starvation: a continuous vid_req starves the CPU. This is by design; video has hard timing.
- In-flight at clear start: reads already granted still complete and return correct data, because the RAM has already latched their address. A CPU op in flight completes its ack. Pending CPU requests not yet granted wait for RUN.
- Width: the clear counter is ADDR_W+1 bits so the terminal count is detected without wrap; addresses are not wrapped externally.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults; state enum {ST_CLEAR, ST_RUN}; return-source tag enum {SRC_NONE, SRC_VID, SRC_CPU}.
- One natural sub-module: ram_clear_seq (counter, terminal detect, busy flag). The arbiter and the 2-stage tag/return pipeline stay inline.

Test Plan:
- Reset with CLEAR_ON_RESET=1 and RAM preloaded 0xFF -> clear_busy high exactly 2048 cycles; every address reads 0x00 afterwards; cpu_req held during clear is acked only after clear_busy falls.
- CPU write 0xA5 to 0x123, then CPU read 0x123 -> each ack 2 cycles after grant; cpu_dout=0xA5.
- vid_req on 4 consecutive cycles, addresses 0x000..0x003, preloaded 0x10..0x13 -> vid_valid on 4 consecutive cycles, 2 after each request, data 0x10..0x13.
- cpu_req and vid_req asserted together -> video granted first; CPU granted the first cycle vid_req=0; cpu_ack latency counted from that grant.
- clear_req one cycle after a video read grant of address 0x050 holding 0x77 -> vid_valid with 0x77 still delivered; clear then zeroes 0x050.
- Async reset asserted mid-clear at counter 0x300 -> outputs 0 immediately; the clear restarts from address 0 after release.
